// File: rtl/mem_responder_pkg.sv
// Shared types for the RV32I memory-port responder: word type, FSM state, counter sizing.
// Benches import this to probe the responder's state.
package mem_responder_pkg;

  // Same shape as the core's rv32i_word so the port drops straight into the datapath.
  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Counter only ever holds LATENCY-1 down to 1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned latency);
    int unsigned w;
    w = 1;
    if (latency > 2) w = $clog2(latency);
    return w;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// RV32I core memory port: core drives requests (master), responder returns data/pulse (slave).
// Requests are level-held until mem_resp; mem_err only exists when MEM_RESPONDER_ERR_EN is defined.
interface mem_responder_if;
  import mem_responder_pkg::*;

  rv32i_word  mem_address;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  rv32i_word  mem_wdata;
  rv32i_word  mem_rdata;
  logic       mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
  logic       mem_err;
`endif

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
`ifdef MEM_RESPONDER_ERR_EN
    , input mem_err
`endif
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
`ifdef MEM_RESPONDER_ERR_EN
    , output mem_err
`endif
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port DEPTH_WORDS x 32 word array, byte-lane writes, read data registered one edge after re.
// No backpressure; rdata holds its last value until the next re, cleared by rst (contents are not).
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  rv32i_word     wdata,
  output rv32i_word     rdata
);

  rv32i_word mem_q [DEPTH_WORDS];
  rv32i_word rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the RV32I core; mem_resp pulses LATENCY cycles after accept. Optional MEM_RESPONDER_ERR_EN adds mem_err.
// No backpressure: requests are accepted only in IDLE and must be held by the core until mem_resp.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = cnt_width(LATENCY);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  rv32i_word     wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          wr_q, wr_d;

  logic [AW-1:0] in_idx;
  logic          arr_re;
  logic [3:0]    arr_we;
  logic [AW-1:0] arr_addr;
  rv32i_word     arr_rdata;
  rv32i_word     unused_addr;

  assign in_idx      = bus.mem_address[AW+1:2];
  assign unused_addr = bus.mem_address;

`ifdef MEM_RESPONDER_ERR_EN
  logic oor_q, oor_d, err_q, err_d, rzero_q, rzero_d, in_oor;
  assign in_oor = (bus.mem_address >> (AW + 2)) != '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    arr_re   = 1'b0;
    arr_we   = 4'b0;
    arr_addr = addr_q;
`ifdef MEM_RESPONDER_ERR_EN
    oor_d    = oor_q;
    err_d    = err_q;
    rzero_d  = rzero_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Array is addressed straight from the bus so a LATENCY=1 read can load on the accept edge.
        arr_addr = in_idx;
        if (bus.mem_read || bus.mem_write) begin
          addr_d  = in_idx;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          wr_d    = bus.mem_write;
`ifdef MEM_RESPONDER_ERR_EN
          oor_d   = in_oor;
          err_d   = in_oor || (bus.mem_read && bus.mem_write)
                    || (bus.mem_write && bus.mem_byte_enable == 4'b0);
`endif
          if (LATENCY == 1) begin
            state_d = RESP;
            arr_re  = !bus.mem_write;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          arr_re  = !wr_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef MEM_RESPONDER_ERR_EN
        if (wr_q && !oor_q) arr_we = be_q;
`else
        if (wr_q) arr_we = be_q;
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_RESPONDER_ERR_EN
    if (arr_re) rzero_d = (state_q == IDLE) ? in_oor : oor_q;
`endif
    if (rst) arr_we = 4'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    wr_q    <= wr_d;
  end

`ifdef MEM_RESPONDER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
      rzero_q <= 1'b0;
    end else begin
      oor_q   <= oor_d;
      err_q   <= err_d;
      rzero_q <= rzero_d;
    end
  end

  assign bus.mem_err   = (state_q == RESP) && !rst && err_q;
  assign bus.mem_rdata = rzero_q ? '0 : arr_rdata;
`else
  assign bus.mem_rdata = arr_rdata;
`endif

  assign bus.mem_resp = (state_q == RESP) && !rst;

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .re   (arr_re),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus random traffic against a word-array model.
// A second LATENCY=1 instance covers the single-cycle and write-wins cases.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
  localparam int DEPTH1 = 16;

  logic clk;
  logic rst;

  mem_responder_if bus_if ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request, held through the resp cycle and dropped after it; checks latency and pulse width.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic err);
    int lat;
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    bus_if.mem_read        = rd;
    bus_if.mem_write       = wr;
    bus_if.mem_address     = addr;
    bus_if.mem_byte_enable = be;
    bus_if.mem_wdata       = wd;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus_if.mem_resp) begin
        lat   = k;
        rdata = bus_if.mem_rdata;
`ifdef MEM_RESPONDER_ERR_EN
        err   = bus_if.mem_err;
`endif
      end
    end
    chk_eq("latency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    chk_eq("resp_pulse", 32'(bus_if.mem_resp), 32'd0);
    bus_if.mem_read  = 1'b0;
    bus_if.mem_write = 1'b0;
  endtask

  // do_op plus reference-model expectations; the model is updated for writes.
  task automatic op_chk(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, output logic [31:0] got);
    logic        gerr;
    logic [31:0] exp;
    bit          drop;
    int          idx;
    idx  = int'((addr / 4) % DEPTH);
    drop = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    drop = (addr / (DEPTH * 4)) != 0;
`endif
    do_op(rd, wr, addr, be, wd, got, gerr);
`ifdef MEM_RESPONDER_ERR_EN
    chk_eq({tag, "_err"}, 32'(gerr), 32'(drop || (rd && wr) || (wr && be == 4'h0)));
`endif
    if (wr) begin
      if (!drop)
        for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
      chk_eq({tag, "_hold"}, bus_if.mem_rdata, last_rd);
    end else begin
      exp = drop ? 32'h0 : model[idx];
      chk_eq({tag, "_rd"}, got, exp);
      last_rd = exp;
    end
  endtask

  task automatic held_read(input int last_hi, output int npulse, output int second_edge);
    npulse      = 0;
    second_edge = -1;
    @(negedge clk);
    bus_if.mem_read    = 1'b1;
    bus_if.mem_write   = 1'b0;
    bus_if.mem_address = 32'h40;
    for (int e = 0; e < 4 * LAT + 6; e++) begin
      @(posedge clk); #1;
      if (bus_if.mem_resp) begin
        npulse++;
        if (npulse == 2) second_edge = e;
      end
      if (e == last_hi) bus_if.mem_read = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          np, e2;
    logic        seen;
    bit          rd, wr;
    int          kind, word, hi;
    logic [31:0] addr;

    rst = 1'b1;
    bus_if.mem_read = 1'b0; bus_if.mem_write = 1'b0; bus_if.mem_address = '0;
    bus_if.mem_byte_enable = '0; bus_if.mem_wdata = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_address = '0;
    bus1.mem_byte_enable = '0; bus1.mem_wdata = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("rst_resp", 32'(bus_if.mem_resp), 32'd0);
    chk_eq("rst_rdata", bus_if.mem_rdata, 32'h0);
    chk_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk_eq("rst_rdata_l1", bus1.mem_rdata, 32'h0);

    for (int w = 0; w < 32; w++) op_chk("preload", 1'b0, 1'b1, 32'(w * 4), 4'hF, $urandom, got);

    op_chk("beef_wr", 1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, got);
    op_chk("beef", 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, got);
    chk_eq("beef_lit", got, 32'hDEADBEEF);

    op_chk("be_init", 1'b0, 1'b1, 32'h40, 4'hF, 32'h11223344, got);
    op_chk("be_wr", 1'b0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, got);
    op_chk("be", 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, got);
    chk_eq("be_lit", got, 32'h11BB33DD);

    held_read(LAT, np, e2);
    chk_eq("held1_pulses", 32'(np), 32'd1);
    held_read(LAT + 1, np, e2);
    chk_eq("held2_pulses", 32'(np), 32'd2);
    chk_eq("held2_edge", 32'(e2), 32'(2 * LAT));
    last_rd = model[16];

    op_chk("wrap_wr", 1'b0, 1'b1, 32'h1000, 4'hF, 32'h12345678, got);
    op_chk("wrap_rd0", 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, got);
`ifdef MEM_RESPONDER_ERR_EN
    op_chk("wrap_rdhi", 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, got);
    chk_eq("wrap_rdhi_lit", got, 32'h0);
`else
    chk_eq("wrap_lit", got, 32'h12345678);
`endif

    // Reset while a write to 0x20 sits in WAIT.
    @(negedge clk);
    bus_if.mem_write = 1'b1; bus_if.mem_address = 32'h20;
    bus_if.mem_byte_enable = 4'hF; bus_if.mem_wdata = ~model[8];
    @(posedge clk); #1;
    chk_eq("rstmid_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    seen = bus_if.mem_resp;
    chk_eq("rstmid_state", 32'(dut.state_q), 32'(IDLE));
    chk_eq("rstmid_rdata", bus_if.mem_rdata, 32'h0);
    rst = 1'b0;
    bus_if.mem_write = 1'b0;
    @(posedge clk); #1;
    seen = seen | bus_if.mem_resp;
    chk_eq("rstmid_resp", 32'(seen), 32'd0);
    last_rd = '0;
    op_chk("rstmid", 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, got);

    // LATENCY=1 instance: read+write together is a write, resp right after accept.
    @(negedge clk);
    bus1.mem_read = 1'b1; bus1.mem_write = 1'b1; bus1.mem_address = 32'h8;
    bus1.mem_byte_enable = 4'hF; bus1.mem_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk_eq("l1_wr_resp", 32'(bus1.mem_resp), 32'd1);
`ifdef MEM_RESPONDER_ERR_EN
    chk_eq("l1_err", 32'(bus1.mem_err), 32'd1);
`endif
    @(posedge clk); #1;
    chk_eq("l1_wr_pulse", 32'(bus1.mem_resp), 32'd0);
    chk_eq("l1_rd_hold", bus1.mem_rdata, 32'h0);
    bus1.mem_read = 1'b1; bus1.mem_write = 1'b0;
    @(posedge clk); #1;
    chk_eq("l1_rd_resp", 32'(bus1.mem_resp), 32'd1);
    chk_eq("l1_rd", bus1.mem_rdata, 32'hCAFEF00D);
    bus1.mem_read = 1'b0;
    @(posedge clk); #1;
    chk_eq("l1_rd_pulse", 32'(bus1.mem_resp), 32'd0);

    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      rd   = (kind != 2);
      wr   = (kind >= 2);
      word = int'($urandom_range(0, 31));
      hi   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      addr = 32'(hi * 32'h1000 + word * 4 + int'($urandom_range(0, 3)));
      op_chk("rnd", rd, wr, addr, 4'($urandom), $urandom, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Synthesizable memory-side responder for the multicycle RV32I core's memory port. It serves the core controller's mem_read / mem_write / mem_byte_enable requests from an internal word array, and returns a one-cycle mem_resp pulse after a fixed, parameterized latency. It stands in for the memory subsystem in the datapath top level and in the core benches, as the other end of the fetch/load/store handshake.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, at least 2.
LATENCY, 2, cycles from request accept to mem_resp; at least 1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_address  in  32  byte address from the core; bits [1:0] ignored
mem_read  in  1  read request, held by the initiator until mem_resp
mem_write  in  1  write request, held by the initiator until mem_resp
mem_byte_enable  in  4  write lane enables; bit i selects byte i (bits 8i+7:8i)
mem_wdata  in  32  write data
mem_rdata  out  32  read data; valid in the mem_resp cycle, held until the next read completes
mem_resp  out  1  single-cycle completion pulse

Behaviour:
- Reset values: mem_resp=0, mem_rdata=0, state=IDLE, latency counter=0. Array contents are not reset.
- Word index = mem_address[AW+1:2], where AW=$clog2(DEPTH_WORDS). Higher address bits are dropped, so addresses wrap modulo DEPTH_WORDS*4.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read or mem_write is high, accept the request and latch address, wdata, byte enables and op.
  - Op decode: write if mem_write=1, including the read+write case (write wins); otherwise read.
  - Go to RESP if LATENCY=1, else go to WAIT with counter=LATENCY-1.
- WAIT: decrement counter each cycle; go to RESP when counter reaches 1.
- Latency: request first seen high in IDLE at edge t gives mem_resp=1 for exactly the cycle after edge t+LATENCY-1. In other words, mem_resp rises LATENCY cycles after the accept cycle.
- RESP:
  - mem_resp=1 for this cycle only.
  - Read: mem_rdata is loaded at the edge entering RESP with the full 32-bit word; byte enables are ignored.
  - Write: array lanes with be[i]=1 are updated at the edge leaving RESP. be=0000 still completes with a resp and leaves the array unchanged.
  - Next state is always IDLE. Request lines are ignored in RESP; the initiator still drives them during the resp cycle.
- Back-to-back: a request high in the IDLE cycle right after RESP is a new request. Minimum spacing is 1 idle cycle between pulses.
- Input changes after accept are ignored; only latched values are used.
- Read after write to the same word returns the new data.
- rst in any state aborts the operation: no array write, no mem_resp, and the FSM returns to IDLE on the next edge.
- mem_rdata is not updated by writes.

Optional Feature:
Macro MEM_RESPONDER_ERR_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0), asserted only in the resp cycle.
  - mem_err=1 when any of these holds: mem_address[31:AW+2] != 0 (out of range), mem_read and mem_write were both high at accept, or a write was accepted with be=0000.
  - On an out-of-range access, reads return mem_rdata=0 and writes are dropped.
- Undefined:
  - No mem_err port; wrap-around and write-wins behaviour as described above.

Decomposition:
- The rv32i_word type comes from rv32i_types.
- Add a small shared package mem_responder_pkg holding the FSM state enum (IDLE/WAIT/RESP) and a function computing the latency counter width, so benches can probe state.
- One sub-module, mem_responder_array: a single-port, DEPTH_WORDS x 32 array with 4 byte-lane write enables and a synchronous read.
- The FSM, counter and latches stay in mem_responder.

Test Plan:
- Reset, then read: LATENCY=2, preload word 0x10 = 0xDEADBEEF, mem_read with addr 0x40 -> mem_resp high exactly 2 cycles after accept for 1 cycle, mem_rdata=0xDEADBEEF.
- Byte-enable write: word 0x40 = 0x11223344; write addr 0x40, be=0101, wdata=0xAABBCCDD -> then read returns 0x11BB33DD.
- Held request: mem_read held through the resp cycle and dropped one cycle later -> exactly one mem_resp pulse. Holding it 2 cycles past resp -> a second pulse LATENCY cycles after the IDLE re-accept.
- Wrap-around: DEPTH_WORDS=1024, write 0x12345678 to 0x1000 -> read of 0x0000 returns 0x12345678. With MEM_RESPONDER_ERR_EN, the same write gives mem_err=1, the array is unchanged and a read of 0x1000 returns 0.
- Reset mid-op: assert rst during WAIT of a write to 0x20 -> no mem_resp, word 0x20 unchanged, FSM in IDLE, mem_rdata=0.
- LATENCY=1 build: read accepted at cycle n -> mem_resp at cycle n+1. Read and write both high -> treated as a write.
